ibex_fp_register_file: RTL

- RV32F floating-point register file: 32 x 32-bit registers f0..f31, three asynchronous read ports and one synchronous write port.
- The write port is the receiving end of the writeback stage's FRF write interface (frf_we_wb / rf_waddr_wb / frf_wdata_wb).
- The read ports serve ID/EX: rs1/rs2 for arithmetic, rs3 for fused multiply-add.
- An integrated pending-write scoreboard tracks destination registers of in-flight multi-cycle FPU ops and FP loads. ID/EX uses it as a RAW hazard indication.

---
 rtl/ibex_fp_register_file.sv | 110 +++++++++++
 1 files changed

// File: rtl/ibex_fp_register_file.sv
// RV32F floating-point register file: 32 x 32-bit, three async read ports, one sync write port,
// plus a pending-write scoreboard. Optional same-cycle write-to-read bypass: RV32F_FRF_WRITE_BYPASS_EN.
module ibex_fp_register_file #(
  parameter int unsigned DataWidth    = 32,
  parameter bit          ScoreboardEn = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           raddr_c_i,
  output logic [DataWidth-1:0] rdata_c_o,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 we_i,
  input  logic                 pend_set_i,
  input  logic [4:0]           pend_addr_i,
  input  logic                 pend_flush_i,
  output logic                 pend_a_o,
  output logic                 pend_b_o,
  output logic                 pend_c_o,
  output logic                 pend_any_o,
  output logic                 pend_err_o
);

  localparam int unsigned NumRegs = 32;

  logic [DataWidth-1:0] mem_q [NumRegs];
  logic                 byp_a, byp_b, byp_c;

  // Register array; f0 is an ordinary register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef RV32F_FRF_WRITE_BYPASS_EN
  assign byp_a = we_i && (raddr_a_i == waddr_i);
  assign byp_b = we_i && (raddr_b_i == waddr_i);
  assign byp_c = we_i && (raddr_c_i == waddr_i);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
  assign byp_c = 1'b0;
`endif

  assign rdata_a_o = byp_a ? wdata_i : mem_q[raddr_a_i];
  assign rdata_b_o = byp_b ? wdata_i : mem_q[raddr_b_i];
  assign rdata_c_o = byp_c ? wdata_i : mem_q[raddr_c_i];

  if (ScoreboardEn) begin : g_sb
    logic [NumRegs-1:0] pend_q, pend_d;
    logic               err_q, err_d;

    // Flush beats everything; a set is applied after the writeback clear so the newer producer wins.
    always_comb begin
      pend_d = pend_q;
      err_d  = 1'b0;
      if (pend_flush_i) begin
        pend_d = '0;
      end else begin
        if (we_i) begin
          pend_d[waddr_i] = 1'b0;
        end
        if (pend_set_i) begin
          pend_d[pend_addr_i] = 1'b1;
        end
        err_d = we_i && !pend_q[waddr_i] && (|pend_q);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pend_q <= '0;
        err_q  <= 1'b0;
      end else begin
        pend_q <= pend_d;
        err_q  <= err_d;
      end
    end

    assign pend_a_o   = pend_q[raddr_a_i] & ~byp_a;
    assign pend_b_o   = pend_q[raddr_b_i] & ~byp_b;
    assign pend_c_o   = pend_q[raddr_c_i] & ~byp_c;
    assign pend_any_o = |pend_q;
    assign pend_err_o = err_q;
  end else begin : g_no_sb
    logic unused_sb;
    assign unused_sb  = ^{pend_set_i, pend_addr_i, pend_flush_i, byp_a, byp_b, byp_c};
    assign pend_a_o   = 1'b0;
    assign pend_b_o   = 1'b0;
    assign pend_c_o   = 1'b0;
    assign pend_any_o = 1'b0;
    assign pend_err_o = 1'b0;
  end

`ifndef SYNTHESIS
  a_no_set_in_reset : assert property (@(posedge clk_i) !rst_ni |-> !pend_set_i);
  a_waddr_known     : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                       we_i |-> !$isunknown(waddr_i));
`endif

endmodule
